// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions.
// Used by the IF/ID, EX/MEM and MEM/WB pipeline registers.
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int REG_ZERO   = 0;

  function automatic int popcount(
    input logic [63:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < 64; i++)
      n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM/WB bundle: per-lane memory-stage inputs
// and the registered write-back commands.
interface mem_wb_pipe_if
  import mips_pipe_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
);

  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_mem_data;
  logic [LANES*DATA_W-1:0] in_alu;
  logic [LANES*REG_AW-1:0] in_rd;
  logic [LANES*REG_AW-1:0] in_rt;
  logic [LANES-1:0]        in_sel_mem;
  logic [LANES-1:0]        in_sel_rt;
  logic [LANES-1:0]        in_wr;

  logic [LANES-1:0]        wb_valid;
  logic [LANES-1:0]        wb_we;
  logic [LANES*REG_AW-1:0] wb_addr;
  logic [LANES*DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]        retired_cnt;

  modport master (
    output in_valid, in_mem_data, in_alu,
    output in_rd, in_rt,
    output in_sel_mem, in_sel_rt, in_wr,
    input  wb_valid, wb_we, wb_addr,
    input  wb_data, retired_cnt
  );

  modport slave (
    input  in_valid, in_mem_data, in_alu,
    input  in_rd, in_rt,
    input  in_sel_mem, in_sel_rt, in_wr,
    output wb_valid, wb_we, wb_addr,
    output wb_data, retired_cnt
  );

endinterface

// File: rtl/mem_wb_lane.sv
// One MEM/WB lane: destination and data select
// plus the r0 write filter.
module mem_wb_lane
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              valid_i,
  input  logic              wr_i,
  input  logic              sel_mem_i,
  input  logic              sel_rt_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rt_i,
  output logic [REG_AW-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              we_raw_o
);

  assign addr_o = sel_rt_i ? rt_i : rd_i;
  assign data_o = sel_mem_i ? mem_data_i : alu_i;

  assign we_raw_o = valid_i & wr_i &
                    (addr_o != REG_AW'(REG_ZERO));

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: N lanes, stall/flush,
// same-cycle WAW filtering and a retired counter.
module mem_wb_pipe
  import mips_pipe_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  mem_wb_pipe_if.slave  bus
);

  logic [LANES*REG_AW-1:0] addr_d, addr_q;
  logic [LANES*DATA_W-1:0] data_d, data_q;
  logic [LANES-1:0]        we_raw, we_d, we_q;
  logic [LANES-1:0]        valid_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_wb_lane #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_lane (
      .valid_i    (bus.in_valid[g]),
      .wr_i       (bus.in_wr[g]),
      .sel_mem_i  (bus.in_sel_mem[g]),
      .sel_rt_i   (bus.in_sel_rt[g]),
      .mem_data_i (bus.in_mem_data[g*DATA_W +: DATA_W]),
      .alu_i      (bus.in_alu[g*DATA_W +: DATA_W]),
      .rd_i       (bus.in_rd[g*REG_AW +: REG_AW]),
      .rt_i       (bus.in_rt[g*REG_AW +: REG_AW]),
      .addr_o     (addr_d[g*REG_AW +: REG_AW]),
      .data_o     (data_d[g*DATA_W +: DATA_W]),
      .we_raw_o   (we_raw[g])
    );
  end

  // Younger lane wins when two lanes hit the same register.
  always_comb begin
    we_d = we_raw;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (we_raw[i] && we_raw[j] &&
            addr_d[i*REG_AW +: REG_AW] ==
            addr_d[j*REG_AW +: REG_AW])
          we_d[i] = 1'b0;
      end
    end
  end

  assign cnt_d = cnt_q +
    CNT_W'(popcount(64'(bus.in_valid)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
      we_q    <= '0;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end else if (!stall) begin
      valid_q <= bus.in_valid;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_valid    = valid_q;
  assign bus.wb_we       = we_q;
  assign bus.wb_addr     = addr_q;
  assign bus.wb_data     = data_q;
  assign bus.retired_cnt = cnt_q;

endmodule
